// File: rtl/core_mem.sv
// core_mem: memory stage of the 5-stage pipeline.
// Issues byte/half/word/dword loads and stores over a req/ready data-memory
// handshake. It formats load data by size and sign, stalls upstream while a
// transaction is outstanding, and registers the writeback bundle (MEM_data is
// forwarded back to execute).
// Optional feature: define MEM_PERF_COUNTERS_EN to add the saturating
// perf_stall_cycles / perf_mem_ops counters.
module core_mem #(
  parameter int TIMEOUT = 255,  // WAIT cycles before bus_error; 0 disables
  parameter int CNT_W   = 16    // watchdog counter width
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [63:0] ex_out,
  input  logic [63:0] ex_B_data,
  input  logic [4:0]  ex_W_regnum,
  input  logic        ex_write_enable,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_mem_size,
  input  logic        ex_mem_signed,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [63:0] dmem_rdata,
  output logic        stall,
  output logic [63:0] MEM_data,
  output logic [4:0]  wb_regnum,
  output logic        wb_we,
  output logic        addr_error,
  output logic        bus_error
`ifdef MEM_PERF_COUNTERS_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_mem_ops
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // wait_cnt holds the number of WAIT cycles already completed. The timeout
  // therefore fires on the TIMEOUT-th WAIT cycle, when the count reaches
  // TIMEOUT-1.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_next;
  logic [2:0]       off;
  logic [7:0]       be_base;
  logic [2:0]       align_mask;
  logic             misaligned, is_mem, mem_op, misaligned_op;
  logic [7:0]       be_c;
  logic [63:0]      wdata_c;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;
  logic             squashed;
  logic [63:0]      load_hold;
  logic [2:0]       ld_off;
  logic [1:0]       ld_size;
  logic             ld_signed;

  // Shift the addressed lane down, truncate to the access size, then extend.
  function automatic logic [63:0] format_load(input logic [63:0] rdata,
                                              input logic [2:0]  lane,
                                              input logic [1:0]  size,
                                              input logic        sgn);
    logic [63:0] r;
    r = rdata >> {lane, 3'b000};
    unique case (size)
      2'd0:    return sgn ? {{56{r[7]}},  r[7:0]}  : {56'b0, r[7:0]};
      2'd1:    return sgn ? {{48{r[15]}}, r[15:0]} : {48'b0, r[15:0]};
      2'd2:    return sgn ? {{32{r[31]}}, r[31:0]} : {32'b0, r[31:0]};
      default: return r;
    endcase
  endfunction

  // Size decode: base byte-enable pattern and low-address alignment mask.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    be_base    = 8'hFF;
    align_mask = 3'b111;
    unique case (ex_mem_size)
      2'd0:    begin be_base = 8'h01; align_mask = 3'b000; end
      2'd1:    begin be_base = 8'h03; align_mask = 3'b001; end
      2'd2:    begin be_base = 8'h0F; align_mask = 3'b011; end
      default: begin be_base = 8'hFF; align_mask = 3'b111; end
    endcase
  end

  assign off           = ex_out[2:0];
  assign misaligned    = |(off & align_mask);
  assign is_mem        = ex_mem_read | ex_mem_write;
  assign mem_op        = is_mem & ~misaligned;
  assign misaligned_op = is_mem & misaligned;
  assign be_c          = be_base << off;
  assign wdata_c       = ex_B_data << {off, 3'b000};
  assign timeout_hit   = (TIMEOUT != 0) && (wait_cnt == TIMEOUT_LAST);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and stall. Stall is held low during reset so upstream is not frozen.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    unique case (state)
      IDLE: if (mem_op && !flush && !reset) begin
        stall      = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (dmem_ready)       state_next = DONE;
        else if (timeout_hit) state_next = IDLE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request, watchdog, load-hold and writeback registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      MEM_data   <= '0;
      wb_regnum  <= '0;
      wb_we      <= 1'b0;
      addr_error <= 1'b0;
      bus_error  <= 1'b0;
      wait_cnt   <= '0;
      squashed   <= 1'b0;
      load_hold  <= '0;
      ld_off     <= '0;
      ld_size    <= '0;
      ld_signed  <= 1'b0;
    end else begin
      addr_error <= 1'b0;
      bus_error  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_op && !flush) begin
            dmem_req   <= 1'b1;
            dmem_we    <= ex_mem_write;
            dmem_addr  <= {ex_out[63:3], 3'b000};
            dmem_be    <= be_c;
            dmem_wdata <= wdata_c;
            ld_off     <= off;
            ld_size    <= ex_mem_size;
            ld_signed  <= ex_mem_signed;
            wait_cnt   <= '0;
            squashed   <= 1'b0;
            wb_we      <= 1'b0;
          end else begin
            MEM_data   <= ex_out;
            wb_regnum  <= ex_W_regnum;
            wb_we      <= ex_write_enable & ~flush & ~misaligned_op;
            addr_error <= misaligned_op & ~flush;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          // A flushed op still completes on the bus; only its result is dropped.
          if (flush) squashed <= 1'b1;
          if (dmem_ready) begin
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            load_hold <= format_load(dmem_rdata, ld_off, ld_size, ld_signed);
          end else if (timeout_hit) begin
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            bus_error <= 1'b1;
            wb_we     <= 1'b0;
            squashed  <= 1'b0;
          end
        end
        DONE: begin
          wb_we <= ex_write_enable & ex_mem_read & ~squashed & ~flush;
          if (!squashed && !flush) begin
            MEM_data  <= ex_mem_read ? load_hold : ex_out;
            wb_regnum <= ex_W_regnum;
          end
          squashed <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_PERF_COUNTERS_EN
  // Saturating counters of stalled cycles and completed handshakes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_mem_ops      <= '0;
    end else begin
      if (stall && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (state == WAIT && dmem_ready && perf_mem_ops != '1)
        perf_mem_ops <= perf_mem_ops + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_mem.sv
// tb_core_mem: scoreboard bench for core_mem (TIMEOUT=4). Each expected
// writeback is queued when its op is driven and popped when it reaches MEM_data.
module tb_core_mem;

  logic        clock = 1'b0;
  logic        reset, flush;
  logic [63:0] ex_out, ex_B_data;
  logic [4:0]  ex_W_regnum;
  logic        ex_write_enable, ex_mem_read, ex_mem_write, ex_mem_signed;
  logic [1:0]  ex_mem_size;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_be;
  logic        stall, wb_we, addr_error, bus_error;
  logic [63:0] MEM_data;
  logic [4:0]  wb_regnum;

  core_mem #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .ex_out(ex_out), .ex_B_data(ex_B_data), .ex_W_regnum(ex_W_regnum),
    .ex_write_enable(ex_write_enable), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_size(ex_mem_size),
    .ex_mem_signed(ex_mem_signed),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .stall(stall), .MEM_data(MEM_data),
    .wb_regnum(wb_regnum), .wb_we(wb_we), .addr_error(addr_error),
    .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  regnum;
    logic        we;
  } wb_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [63:0] rdata;
    logic [3:0]  ready_after;
    logic [63:0] exp_data;
    logic [7:0]  exp_be;
    logic [63:0] exp_addr;
  } ld_vec_t;

  wb_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic drive_nop();
    ex_out = '0; ex_B_data = '0; ex_W_regnum = '0; ex_write_enable = 1'b0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_mem_size = '0; ex_mem_signed = 1'b0;
  endtask

  task automatic drive_op(input logic [63:0] addr, input logic [63:0] bdata,
                          input logic [4:0] rn, input logic we, input logic rd,
                          input logic wr, input logic [1:0] sz, input logic sg);
    ex_out = addr; ex_B_data = bdata; ex_W_regnum = rn; ex_write_enable = we;
    ex_mem_read = rd; ex_mem_write = wr; ex_mem_size = sz; ex_mem_signed = sg;
  endtask

  // Plays the memory side of one op from its EX presentation (posedge+1) up
  // to the negedge of the first unstalled cycle or a bus_error pulse.
  task automatic run_mem(input int ready_after, input logic [63:0] rdata,
                         input int flush_at, output int stall_cyc,
                         output int req_cyc, output logic saw_bus_err,
                         output logic unstable, output logic [63:0] addr_s,
                         output logic [63:0] wdata_s, output logic [7:0] be_s,
                         output logic we_s);
    logic done;
    stall_cyc = 0; req_cyc = 0; saw_bus_err = 1'b0; unstable = 1'b0; done = 1'b0;
    addr_s = '0; wdata_s = '0; be_s = '0; we_s = 1'b0;
    for (int i = 0; i < 40 && !done && !saw_bus_err; i++) begin
      @(negedge clock);
      if (bus_error) saw_bus_err = 1'b1;
      else begin
        if (stall) stall_cyc++;
        if (dmem_req) begin
          req_cyc++;
          if (req_cyc == 1) begin
            addr_s = dmem_addr; wdata_s = dmem_wdata; be_s = dmem_be; we_s = dmem_we;
          end else if (dmem_addr !== addr_s || dmem_wdata !== wdata_s ||
                       dmem_be !== be_s || dmem_we !== we_s) begin
            unstable = 1'b1;
          end
          flush = (req_cyc == flush_at);
          if (req_cyc == ready_after) begin
            dmem_ready = 1'b1;
            dmem_rdata = rdata;
          end
        end
        if (!stall) done = 1'b1;
        else begin
          @(posedge clock); #1;
          dmem_ready = 1'b0; flush = 1'b0; dmem_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
        end
      end
    end
    if (!done && !saw_bus_err) begin
      checks++; errors++;
      $display("FAIL run_mem_budget: op never completed (stall=%b req=%b)", stall, dmem_req);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
    drive_nop();
    #12;
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, stall, MEM_data,
         wb_regnum, wb_we, addr_error, bus_error} !== '0) begin
      errors++;
      $display("FAIL reset_state: req=%b MEM_data=%h wb_we=%b stall=%b, required all 0",
               dmem_req, MEM_data, wb_we, stall);
    end
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    wb_t e;
    int  stall_seen;
    stall_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      drive_op(64'h1111 * (i + 1), '0, 5'(i + 1), i[0], 1'b0, 1'b0, 2'd0, 1'b0);
      flush = (i == 4);
      exp_q.push_back('{data: 64'h1111 * (i + 1), regnum: 5'(i + 1), we: i[0] && (i != 4)});
      @(negedge clock);
      if (stall) stall_seen++;
      if (i > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (MEM_data !== e.data || wb_we !== e.we || (e.we && wb_regnum !== e.regnum)) begin
          errors++;
          $display("FAIL passthru_%0d: MEM_data=%h wb_we=%b rn=%0d, required %h %b %0d",
                   i - 1, MEM_data, wb_we, wb_regnum, e.data, e.we, e.regnum);
        end
      end
    end
    @(posedge clock); #1;
    drive_nop(); flush = 1'b0;
    @(negedge clock);
    e = exp_q.pop_front();
    checks++;
    if (MEM_data !== e.data || wb_we !== e.we || stall_seen != 0) begin
      errors++;
      $display("FAIL passthru_last: MEM_data=%h wb_we=%b stalls=%0d, required %h %b 0",
               MEM_data, wb_we, stall_seen, e.data, e.we);
    end
  endtask

  task automatic test_loads();
    ld_vec_t v[5];
    wb_t e;
    int st, rq;
    logic be_err, unst;
    logic [63:0] a, wd;
    logic [7:0] be;
    logic w;
    v[0] = '{64'h1003, 2'd0, 1'b1, 64'h0000_0000_8000_0000, 4'd2, 64'hFFFF_FFFF_FFFF_FF80, 8'h08, 64'h1000};
    v[1] = '{64'h1002, 2'd1, 1'b0, 64'h1122_3344_5566_7788, 4'd1, 64'h0000_0000_0000_5566, 8'h0C, 64'h1000};
    v[2] = '{64'h1004, 2'd2, 1'b1, 64'h8765_4321_0000_0000, 4'd3, 64'hFFFF_FFFF_8765_4321, 8'hF0, 64'h1000};
    v[3] = '{64'h1007, 2'd0, 1'b0, 64'hAB00_0000_0000_0000, 4'd1, 64'h0000_0000_0000_00AB, 8'h80, 64'h1000};
    v[4] = '{64'h1008, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 4'd2, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h1008};
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      drive_op(v[i].addr, 64'hFFFF_FFFF_FFFF_FFFF, 5'(10 + i), 1'b1, 1'b1, 1'b0, v[i].size, v[i].sgn);
      exp_q.push_back('{data: v[i].exp_data, regnum: 5'(10 + i), we: 1'b1});
      run_mem(int'(v[i].ready_after), v[i].rdata, 0, st, rq, be_err, unst, a, wd, be, w);
      checks++;
      if (st != int'(v[i].ready_after) + 1 || rq != int'(v[i].ready_after) || a !== v[i].exp_addr ||
          be !== v[i].exp_be || w !== 1'b0 || unst || be_err || dmem_req !== 1'b0) begin
        errors++;
        $display("FAIL load_req_%0d: stall=%0d req=%0d addr=%h be=%h we=%b unstable=%b, required %0d %0d %h %h 0 0",
                 i, st, rq, a, be, w, unst, v[i].ready_after + 1, v[i].ready_after, v[i].exp_addr, v[i].exp_be);
      end
      @(posedge clock); #1;
      drive_nop();
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (MEM_data !== e.data || wb_we !== e.we || wb_regnum !== e.regnum) begin
        errors++;
        $display("FAIL load_data_%0d: MEM_data=%h wb_we=%b rn=%0d, required %h %b %0d",
                 i, MEM_data, wb_we, wb_regnum, e.data, e.we, e.regnum);
      end
    end
  endtask

  task automatic test_store();
    wb_t e;
    int st, rq;
    logic be_err, unst;
    logic [63:0] a, wd;
    logic [7:0] be;
    logic w;
    @(posedge clock); #1;
    drive_op(64'h2006, 64'h0000_0000_0000_BEEF, 5'd3, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
    exp_q.push_back('{data: 64'h2006, regnum: 5'd3, we: 1'b0});
    run_mem(2, '0, 0, st, rq, be_err, unst, a, wd, be, w);
    checks++;
    if (w !== 1'b1 || be !== 8'hC0 || wd !== 64'hBEEF_0000_0000_0000 || a !== 64'h2000 ||
        st != 3 || unst) begin
      errors++;
      $display("FAIL store_req: we=%b be=%h wdata=%h addr=%h stall=%0d, required 1 c0 beef000000000000 2000 3",
               w, be, wd, a, st);
    end
    @(posedge clock); #1;
    drive_nop();
    @(negedge clock);
    e = exp_q.pop_front();
    checks++;
    if (MEM_data !== e.data || wb_we !== e.we) begin
      errors++;
      $display("FAIL store_wb: MEM_data=%h wb_we=%b, required %h %b", MEM_data, wb_we, e.data, e.we);
    end
  endtask

  task automatic test_misaligned();
    int st, rq;
    logic be_err, unst;
    logic [63:0] a, wd;
    logic [7:0] be;
    logic w;
    @(posedge clock); #1;
    drive_op(64'h3002, '0, 5'd4, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
    run_mem(1, '0, 0, st, rq, be_err, unst, a, wd, be, w);
    @(posedge clock); #1;
    drive_nop();
    @(negedge clock);
    checks++;
    if (addr_error !== 1'b1 || wb_we !== 1'b0 || dmem_req !== 1'b0 || st != 0 || rq != 0) begin
      errors++;
      $display("FAIL misaligned: addr_error=%b wb_we=%b req=%b stall=%0d, required 1 0 0 0",
               addr_error, wb_we, dmem_req, st);
    end
    @(negedge clock);
    checks++;
    if (addr_error !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_pulse: addr_error=%b req=%b, required 0 0", addr_error, dmem_req);
    end
  endtask

  task automatic test_timeout();
    int st, rq;
    logic saw, unst;
    logic [63:0] a, wd;
    logic [7:0] be;
    logic w;
    @(posedge clock); #1;
    drive_op(64'h5000, '0, 5'd6, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0);
    run_mem(0, '0, 0, st, rq, saw, unst, a, wd, be, w);
    drive_nop();
    #1;
    checks++;
    if (saw !== 1'b1 || rq != 4 || stall !== 1'b0 || dmem_req !== 1'b0 || wb_we !== 1'b0) begin
      errors++;
      $display("FAIL timeout: bus_error=%b req_cycles=%0d stall=%b req=%b wb_we=%b, required 1 4 0 0 0",
               saw, rq, stall, dmem_req, wb_we);
    end
    @(negedge clock);
    checks++;
    if (bus_error !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: bus_error=%b req=%b, required 0 0", bus_error, dmem_req);
    end
  endtask

  task automatic test_flush_wait();
    wb_t e;
    int st, rq;
    logic saw, unst;
    logic [63:0] a, wd;
    logic [7:0] be;
    logic w;
    @(posedge clock); #1;
    drive_op(64'hCAFE, '0, 5'd2, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    @(posedge clock); #1;
    drive_op(64'h4000, '0, 5'd9, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0);
    exp_q.push_back('{data: 64'hCAFE, regnum: 5'd2, we: 1'b0});
    run_mem(3, 64'h1234, 1, st, rq, saw, unst, a, wd, be, w);
    @(posedge clock); #1;
    drive_nop();
    @(negedge clock);
    e = exp_q.pop_front();
    checks++;
    if (MEM_data !== e.data || wb_we !== e.we || rq != 3 || saw) begin
      errors++;
      $display("FAIL flush_wait: MEM_data=%h wb_we=%b req_cycles=%0d, required %h %b 3",
               MEM_data, wb_we, rq, e.data, e.we);
    end
    // The squash must not leak into the next load.
    @(posedge clock); #1;
    drive_op(64'h4008, '0, 5'd9, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0);
    exp_q.push_back('{data: 64'h1234, regnum: 5'd9, we: 1'b1});
    run_mem(1, 64'h1234, 0, st, rq, saw, unst, a, wd, be, w);
    @(posedge clock); #1;
    drive_nop();
    @(negedge clock);
    e = exp_q.pop_front();
    checks++;
    if (MEM_data !== e.data || wb_we !== e.we || wb_regnum !== e.regnum) begin
      errors++;
      $display("FAIL after_flush: MEM_data=%h wb_we=%b rn=%0d, required %h %b %0d",
               MEM_data, wb_we, wb_regnum, e.data, e.we, e.regnum);
    end
  endtask

  task automatic test_reset_mid_wait();
    wb_t e;
    @(posedge clock); #1;
    drive_op(64'h6000, '0, 5'd8, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0);
    @(posedge clock); #1;
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre: req=%b, required 1", dmem_req);
    end
    #2;
    reset = 1'b1;
    drive_nop();
    #1;
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, stall, MEM_data,
         wb_regnum, wb_we, addr_error, bus_error} !== '0) begin
      errors++;
      $display("FAIL reset_mid_wait: req=%b addr=%h MEM_data=%h stall=%b, required all 0",
               dmem_req, dmem_addr, MEM_data, stall);
    end
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    dmem_ready = 1'b1; dmem_rdata = 64'hFFFF_0000_FFFF_0000;
    @(negedge clock);
    checks++;
    if (dmem_req !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL stray_ready: req=%b stall=%b, required 0 0", dmem_req, stall);
    end
    @(posedge clock); #1;
    dmem_ready = 1'b0;
    drive_op(64'h55, '0, 5'd7, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    exp_q.push_back('{data: 64'h55, regnum: 5'd7, we: 1'b1});
    @(posedge clock); #1;
    drive_nop();
    @(negedge clock);
    e = exp_q.pop_front();
    checks++;
    if (MEM_data !== e.data || wb_we !== e.we || wb_regnum !== e.regnum) begin
      errors++;
      $display("FAIL post_reset_alu: MEM_data=%h wb_we=%b rn=%0d, required %h %b %0d",
               MEM_data, wb_we, wb_regnum, e.data, e.we, e.regnum);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_loads();
    test_store();
    test_misaligned();
    test_timeout();
    test_flush_wait();
    test_reset_mid_wait();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/core_mem.md
Name: core_MEM

Overview:
- Memory stage of the 5-stage pipeline; consumes the execute-stage register outputs.
- Performs byte/half/word/dword loads and stores over a request/ready data-memory handshake, with size/sign formatting.
- Stalls the upstream pipeline while a transaction is outstanding.
- Drives the registered writeback bundle; MEM_data is its forwarding source back into execute.

Parameters:
- TIMEOUT, 255: max WAIT cycles before bus_error; 0 disables the watchdog.
- CNT_W, 16: watchdog counter width; TIMEOUT must fit in CNT_W bits.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  squash current op (exception/redirect)
- ex_out  in  64  execute result; the address for memory ops
- ex_B_data  in  64  store data
- ex_W_regnum  in  5  destination register
- ex_write_enable  in  1  register write request
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store (never both read and write)
- ex_mem_size  in  2  0=byte 1=half 2=word 3=dword
- ex_mem_signed  in  1  sign-extend load result
- dmem_req  out  1  request valid (registered)
- dmem_we  out  1  write request
- dmem_addr  out  64  ex_out with [2:0] cleared
- dmem_wdata  out  64  store data shifted to lane
- dmem_be  out  8  byte enables
- dmem_ready  in  1  transaction complete this cycle
- dmem_rdata  in  64  load data, valid with dmem_ready
- stall  out  1  hold upstream stages (combinational)
- MEM_data  out  64  registered writeback value, forwarded to execute
- wb_regnum  out  5  registered destination
- wb_we  out  1  registered write enable
- addr_error  out  1  one-cycle misalignment pulse
- bus_error  out  1  one-cycle watchdog timeout pulse

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0. Applies immediately; abandons any in-flight request with dmem_req forced low.
- Lanes are little-endian. off = ex_out[2:0]; nbytes = 1<<ex_mem_size.
- Misaligned when off mod nbytes != 0.
- dmem_be = ((1<<nbytes)-1) << off; dmem_wdata = ex_B_data << 8*off.
- Load format: r = dmem_rdata >> 8*off, truncated to nbytes, then sign- or zero-extended to 64 bits.
- mem_op = (ex_mem_read | ex_mem_write) & !misaligned.
- States: IDLE, WAIT, DONE.
  - IDLE, mem_op & !flush: register dmem_req=1, dmem_we, dmem_addr, dmem_be, dmem_wdata; go to WAIT; stall=1.
  - IDLE, misaligned mem op & !flush: addr_error=1 next cycle, wb_we=0, no request, stay IDLE, stall=0.
  - IDLE, otherwise: pass-through next edge: MEM_data<=ex_out, wb_regnum, wb_we<=ex_write_enable & !flush. Latency 1.
  - WAIT: stall=1; request outputs held stable; counter increments each cycle.
    - On dmem_ready: dmem_req<=0; capture formatted load data into a hold register; go to DONE.
    - Ready on the first WAIT cycle is legal.
  - WAIT, TIMEOUT!=0 and counter==TIMEOUT without ready: dmem_req<=0, bus_error pulse, wb_we=0, go to IDLE.
  - DONE: stall=0 so upstream advances this edge.
    - MEM_data<=load hold data (store: ex_out); wb_we<=ex_write_enable & ex_mem_read & !squashed; go to IDLE.
    - No reissue of the same op.
- Load-use latency: minimum 3 cycles from EX presentation to MEM_data valid.
- flush in WAIT: the bus transaction is not aborted. A squashed flag is set; on completion the result is discarded (wb_we=0) and the flag clears in DONE.
- flush in IDLE/DONE: wb_we<=0, no request issued.
- dmem_ready outside WAIT is ignored.

Optional Feature:
- MEM_PERF_COUNTERS_EN defined: adds outputs perf_stall_cycles[31:0] and perf_mem_ops[31:0].
  - perf_stall_cycles increments every cycle stall=1.
  - perf_mem_ops increments on each completed dmem_ready handshake.
  - Both saturate at all-ones; both reset to 0.
- Undefined: ports and logic absent, behaviour otherwise identical.

Test Plan:
- Load byte signed at ex_out=0x1003, rdata=0x00000000_80000000, ready after 2 WAIT cycles -> dmem_addr=0x1000, be=0x08; MEM_data=0xFFFF_FFFF_FFFF_FF80, wb_we=1; stall high exactly 3 cycles.
- Store half at 0x2006, B_data=0xBEEF -> dmem_we=1, be=0xC0, wdata=0xBEEF_0000_0000_0000; wb_we=0 after completion.
- Load word at 0x3002 -> addr_error pulses 1 cycle, dmem_req never asserts, wb_we=0, stall=0.
- TIMEOUT=4, ready never asserted -> dmem_req drops after 4 WAIT cycles, bus_error pulse, state IDLE, stall=0.
- Flush during WAIT of dword load, ready later with rdata=0x1234 -> transaction completes, wb_we=0, MEM_data unchanged by the load.
- Reset asserted mid-WAIT -> dmem_req=0 and all outputs 0 immediately; later ready ignored; next ALU op ex_out=0x55 passes through with MEM_data=0x55 one cycle later.
